// File: rtl/cpu_muldiv.sv
// cpu_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// Multiplies use radix-2 shift-add and divides use restoring shift-subtract,
// one bit per cycle. Divide by zero and signed overflow finish in one cycle.
// Optional build macro CPU_MULDIV_FAST_MUL_EN replaces the iterative multiply
// with a single-cycle combinational multiplier. Division is the same in both builds.
module cpu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          op_reg, op_next;
  logic [2*XLEN-1:0]   acc_reg, acc_next;     // product, or quotient in the low half
  logic [XLEN-1:0]     rem_reg, rem_next;     // partial remainder
  logic [XLEN-1:0]     opb_reg, opb_next;     // multiplicand / divisor magnitude
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic                neg_res_reg, neg_res_next;
  logic                neg_rem_reg, neg_rem_next;
  logic [XLEN-1:0]     result_reg, result_next;

  // Operand decode on the request inputs
  logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
  assign b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
  assign a_neg    = a_signed && src_a[XLEN-1];
  assign b_neg    = b_signed && src_b[XLEN-1];
  assign a_mag    = a_neg ? -src_a : src_a;
  assign b_mag    = b_neg ? -src_b : src_b;
  assign div_zero = op[2] && (src_b == '0);
  assign div_ovf  = ((op == 3'd4) || (op == 3'd6)) && (src_a == SMIN) && (src_b == '1);

  // One iteration of each algorithm, from the registered working state
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_step, prod_fix;
  logic [XLEN-1:0]   quo_step, rem_step, quo_fix, rem_fix;
  logic              div_ok;

  assign mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
  assign mul_step  = {mul_sum, acc_reg[XLEN-1:1]};
  // Trial subtraction is XLEN+1 bits so the borrow shows up in the top bit
  assign div_shift = {rem_reg, acc_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opb_reg};
  assign div_ok    = ~div_diff[XLEN];
  assign rem_step  = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign quo_step  = {acc_reg[XLEN-2:0], div_ok};

  // Sign correction applied to the final iteration's values
  assign prod_fix = neg_res_reg ? -mul_step : mul_step;
  assign quo_fix  = neg_res_reg ? -quo_step : quo_step;
  assign rem_fix  = neg_rem_reg ? -rem_step : rem_step;

`ifdef CPU_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = a_signed ? {{XLEN{src_a[XLEN-1]}}, src_a} : {{XLEN{1'b0}}, src_a};
  assign fast_b    = b_signed ? {{XLEN{src_b[XLEN-1]}}, src_b} : {{XLEN{1'b0}}, src_b};
  assign fast_prod = fast_a * fast_b;
`endif

  // Next-state and datapath update; everything holds by default
  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    acc_next     = acc_reg;
    rem_next     = rem_reg;
    opb_next     = opb_reg;
    cnt_next     = cnt_reg;
    neg_res_next = neg_res_reg;
    neg_rem_next = neg_rem_reg;
    result_next  = result_reg;
    case (state_reg)
      IDLE: begin
        if (start && !flush) begin
          op_next      = op;
          acc_next     = {{XLEN{1'b0}}, a_mag};
          rem_next     = '0;
          opb_next     = b_mag;
          cnt_next     = CW'(XLEN);
          neg_res_next = a_neg ^ b_neg;
          neg_rem_next = a_neg;
          if (div_zero) begin
            result_next = op[1] ? src_a : '1;
            state_next  = DONE;
          end else if (div_ovf) begin
            result_next = op[1] ? '0 : src_a;
            state_next  = DONE;
`ifdef CPU_MULDIV_FAST_MUL_EN
          end else if (!op[2]) begin
            result_next = (op == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
            state_next  = DONE;
`endif
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        cnt_next = cnt_reg - CW'(1);
        acc_next = op_reg[2] ? {{XLEN{1'b0}}, quo_step} : mul_step;
        rem_next = op_reg[2] ? rem_step : rem_reg;
        if (flush) begin
          state_next = IDLE;
        end else if (cnt_reg == CW'(1)) begin
          state_next = DONE;
          case (op_reg)
            3'd0:       result_next = prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       result_next = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5: result_next = quo_fix;
            default:    result_next = rem_fix;
          endcase
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      op_reg      <= '0;
      acc_reg     <= '0;
      rem_reg     <= '0;
      opb_reg     <= '0;
      cnt_reg     <= '0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      result_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      acc_reg     <= acc_next;
      rem_reg     <= rem_next;
      opb_reg     <= opb_next;
      cnt_reg     <= cnt_next;
      neg_res_reg <= neg_res_next;
      neg_rem_reg <= neg_rem_next;
      result_reg  <= result_next;
    end
  end

  assign busy   = (state_reg != IDLE);
  assign valid  = (state_reg == DONE);
  assign result = result_reg;

endmodule

// File: tb/tb_cpu_muldiv.sv
// tb_cpu_muldiv: directed and randomized checks of cpu_muldiv against an
// arithmetic reference model. Honours CPU_MULDIV_FAST_MUL_EN for multiply latency.
module tb_cpu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy, valid;
  logic [31:0] result;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_result = 32'd0;

`ifdef CPU_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  cpu_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .busy(busy), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference result straight from the RV32M definitions using 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sp = sa % sb; return sp[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 32'd0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (!o[2]) return MUL_LAT;
    return DIV_LAT;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
  endtask

  // Drop the request and scramble operands; the unit must ignore them
  task automatic release_req();
    start = 1'b0;
    op    = 3'($urandom);
    src_a = $urandom;
    src_b = $urandom;
  endtask

  // Called just after the accept edge; watches cycles 1..lat and the cycle after
  task automatic await_result(input logic [31:0] exp, input int lat, input string tag, input bit hold);
    int got;
    bit busy_ok;
    got = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (valid) begin
        got = c;
        break;
      end
      if (hold) begin
        op    = 3'($urandom);
        src_a = $urandom;
        src_b = $urandom;
      end
    end
    check({tag, " valid cycle"}, 32'(got), 32'(lat));
    check({tag, " result"}, result, exp);
    check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    $display("%s: result=%h valid_cycle=%0d", tag, result, got);
    @(negedge clk);
    check({tag, " idle after"}, {30'd0, busy, valid}, 32'd0);
    check({tag, " result held"}, result, exp);
    last_result = exp;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string tag);
    @(negedge clk);
    drive_req(o, a, b);
    @(posedge clk);
    #1 release_req();
    await_result(exp, lat, tag, 1'b0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          sel;
    bit          seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset valid", {31'd0, valid}, 32'd0);
    check("reset result", result, 32'd0);
    rst_n = 1'b1;

    // Directed cases with hand-computed expectations
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "MUL 7*-3");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "MULH min*min");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "MULHU max*max");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT, "MULHSU -1*2");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, "DIV -7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT, "REM -7/2");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, DIV_LAT, "DIVU 100/7");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, DIV_LAT, "REMU 100/7");
    run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "DIV 5/0");
    run_op(3'd7, 32'd5, 32'd0, 32'd5, 1, "REMU 5/0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "REM ovf");
    run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, MUL_LAT, "MULHU pattern");

    // Flush in cycle 10 of a DIVU, then a new request in cycle 11
    @(negedge clk);
    drive_req(3'd5, 32'd1000, 32'd3);
    @(posedge clk);
    #1 release_req();
    seen = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    if (valid) seen = 1'b1;
    check("flush busy in cycle 10", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy in cycle 11", {31'd0, busy}, 32'd0);
    check("flush no valid", {30'd0, valid, seen}, 32'd0);
    check("flush result kept", result, last_result);
    $display("flush DIVU: busy=%b result=%h", busy, result);
    drive_req(3'd6, 32'hFFFF_FFF9, 32'd2);
    @(posedge clk);
    #1 release_req();
    await_result(32'hFFFF_FFFF, DIV_LAT, "REM after flush", 1'b0);

    // Flush together with start in IDLE: not accepted
    @(negedge clk);
    drive_req(3'd5, 32'd100, 32'd7);
    flush = 1'b1;
    @(posedge clk);
    #1 release_req();
    flush = 1'b0;
    @(negedge clk);
    check("flush+start busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("flush+start idle", {30'd0, busy, valid}, 32'd0);
    $display("flush+start: busy=%b valid=%b", busy, valid);

    // Start held high with changing operands: only the first request counts
    @(negedge clk);
    drive_req(3'd5, 32'd100, 32'd7);
    @(posedge clk);
    #1;
    await_result(32'd14, DIV_LAT, "DIVU held start", 1'b1);
    drive_req(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 release_req();
    await_result(32'hFFFF_FFFE, MUL_LAT, "MULHU after held", 1'b0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if (sel == 2) rb = 32'($urandom_range(1, 15));
      run_op(ro, ra, rb, model(ro, ra, rb), model_lat(ro, ra, rb), $sformatf("rand%0d op%0d", i, ro));
    end

    // Known nonzero result, then reset mid-CALC of a DIV
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "MULHU pre-reset");
    @(negedge clk);
    drive_req(3'd4, 32'd12345, 32'd7);
    @(posedge clk);
    #1 release_req();
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset busy", {31'd0, busy}, 32'd0);
    check("async reset valid", {31'd0, valid}, 32'd0);
    check("async reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid || busy) seen = 1'b1;
    end
    check("no valid after reset", {31'd0, seen}, 32'd0);
    check("result after reset", result, 32'd0);
    $display("reset mid-CALC: busy=%b valid=%b result=%h", busy, valid, result);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
